// File: rtl/id_stage.sv
// -----------------------------------------------------------------------------
// id_stage -- instruction-decode stage of the 5-stage pipeline.
//
// Purpose:
//   Holds the 32-entry register file, reads the operands of the instruction in
//   IFIDIR and writes back results from the MEM/WB latch. Write-through makes a
//   same-cycle writeback visible to the read. The stage produces the IDEX latch
//   (IDEXIR/IDEXA/IDEXB) and six registered bypass selects for execute. It also
//   detects load-use hazards: it stalls fetch and injects a bubble into IDEX.
//
// Ports:
//   clk                  in   pipeline clock, rising edge
//   reset                in   synchronous, active-high
//   IFIDIR               in   instruction being decoded
//   MEMWBIR              in   instruction in writeback
//   MEMWBValue           in   writeback data
//   EXMEMIR              in   instruction in the memory stage
//   stall                out  combinational; high = fetch holds PC and IFIDIR
//   IDEXIR/IDEXA/IDEXB   out  registered IDEX latch
//   bypass{A,B}from{MEM,ALUinWB,LWinWB}  out  registered operand selects
// -----------------------------------------------------------------------------
module id_stage #(
  parameter logic [31:0] BUBBLE_IR = 32'h0000_0020,
  parameter int          DATA_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       IFIDIR,
  input  logic [31:0]       MEMWBIR,
  input  logic [DATA_W-1:0] MEMWBValue,
  input  logic [31:0]       EXMEMIR,
  output logic              stall,
  output logic [31:0]       IDEXIR,
  output logic [DATA_W-1:0] IDEXA,
  output logic [DATA_W-1:0] IDEXB,
  output logic              bypassAfromMEM,
  output logic              bypassAfromALUinWB,
  output logic              bypassAfromLWinWB,
  output logic              bypassBfromMEM,
  output logic              bypassBfromALUinWB,
  output logic              bypassBfromLWinWB
);

  localparam logic [5:0] OP_ALU     = 6'b000000;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_SW      = 6'b101011;
  localparam logic [5:0] OP_CINDC   = 6'b101111;
  localparam logic [5:0] OP_BEQINIT = 6'b000100;

  // ---------------------------------------------------------------------------
  // Decode helpers
  // ---------------------------------------------------------------------------
  function automatic logic writes_rd(input logic [5:0] op);
    return (op == OP_ALU) || (op == OP_CINDC);
  endfunction

  // Destination register, 0 when the instruction writes nothing.
  function automatic logic [4:0] dest_of(input logic [31:0] ir);
    logic [4:0] d;
    d = 5'd0;
    if (writes_rd(ir[31:26]))
      d = ir[15:11];
    else if (ir[31:26] == OP_LW)
      d = ir[20:16];
    return d;
  endfunction

  function automatic logic uses_rs(input logic [5:0] op);
    logic u;
    u = 1'b0;
    case (op)
      OP_ALU, OP_CINDC, OP_LW, OP_SW: u = 1'b1;
      OP_BEQINIT:                     u = 1'b0;
      default:                        u = 1'b0;
    endcase
    return u;
  endfunction

  function automatic logic uses_rt(input logic [5:0] op);
    return (op == OP_ALU) || (op == OP_CINDC) || (op == OP_SW);
  endfunction

  // ---------------------------------------------------------------------------
  // Pipeline state
  // ---------------------------------------------------------------------------
  logic [31:0]       idex_ir_reg;
  logic [DATA_W-1:0] idex_a_reg;
  logic [DATA_W-1:0] idex_b_reg;
  logic [1:0]        bypass_mem_reg;     // [0] = operand A, [1] = operand B
  logic [1:0]        bypass_alu_wb_reg;
  logic [1:0]        bypass_lw_wb_reg;

  logic [DATA_W-1:0] regs [0:31];

  // Field extraction for the instructions being compared.
  logic [5:0] ifid_op;
  logic [5:0] idex_op;
  logic [5:0] exmem_op;
  logic [4:0] wb_dest;

  assign ifid_op  = IFIDIR[31:26];
  assign idex_op  = idex_ir_reg[31:26];
  assign exmem_op = EXMEMIR[31:26];
  assign wb_dest  = dest_of(MEMWBIR);

  // Index 0 describes operand A (rs), index 1 operand B (rt).
  logic [1:0][4:0]        src_addr;
  logic [1:0]             src_used;
  logic [1:0][DATA_W-1:0] src_data;
  logic [1:0]             src_hazard;
  logic [1:0]             byp_mem_next;
  logic [1:0]             byp_alu_wb_next;
  logic [1:0]             byp_lw_wb_next;

  assign src_addr[0] = IFIDIR[25:21];
  assign src_addr[1] = IFIDIR[20:16];
  assign src_used[0] = uses_rs(ifid_op);
  assign src_used[1] = uses_rt(ifid_op);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_operand
      logic live;

      // A select only matters for a source that the opcode really reads, and
      // r0 is never forwarded because it is hard-wired to zero.
      assign live = src_used[gi] && (src_addr[gi] != 5'd0);

      // Write-through: a writeback to the register being read in this cycle
      // is returned directly, so decode never sees a stale register.
      assign src_data[gi] = (src_addr[gi] == 5'd0)    ? '0 :
                            (src_addr[gi] == wb_dest) ? MEMWBValue :
                                                        regs[src_addr[gi]];

      // The instruction now in IDEX will be in MEM next cycle, and it is
      // younger than the one in EXMEM. So its result wins over the WB selects.
      assign byp_mem_next[gi]    = live && writes_rd(idex_op) &&
                                   (idex_ir_reg[15:11] == src_addr[gi]);
      assign byp_alu_wb_next[gi] = live && writes_rd(exmem_op) &&
                                   (EXMEMIR[15:11] == src_addr[gi]) &&
                                   !byp_mem_next[gi];
      assign byp_lw_wb_next[gi]  = live && (exmem_op == OP_LW) &&
                                   (EXMEMIR[20:16] == src_addr[gi]) &&
                                   !byp_mem_next[gi];

      // A load in IDEX has no data until MEM, so a dependent decode must wait.
      assign src_hazard[gi] = src_used[gi] && (idex_op == OP_LW) &&
                              (idex_ir_reg[20:16] != 5'd0) &&
                              (idex_ir_reg[20:16] == src_addr[gi]);
    end
  endgenerate

  assign stall = |src_hazard;

  // ---------------------------------------------------------------------------
  // Register file: reset clears every entry, and reset also blocks writeback.
  // Entry 0 is never written and is masked on read.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++)
        regs[i] <= '0;
    end else if (wb_dest != 5'd0) begin
      regs[wb_dest] <= MEMWBValue;
    end
  end

  // ---------------------------------------------------------------------------
  // IDEX latch and bypass selects
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      idex_ir_reg       <= '0;
      idex_a_reg        <= '0;
      idex_b_reg        <= '0;
      bypass_mem_reg    <= '0;
      bypass_alu_wb_reg <= '0;
      bypass_lw_wb_reg  <= '0;
    end else if (stall) begin
      idex_ir_reg       <= BUBBLE_IR;
      idex_a_reg        <= '0;
      idex_b_reg        <= '0;
      bypass_mem_reg    <= '0;
      bypass_alu_wb_reg <= '0;
      bypass_lw_wb_reg  <= '0;
    end else begin
      idex_ir_reg       <= IFIDIR;
      idex_a_reg        <= src_data[0];
      idex_b_reg        <= src_data[1];
      bypass_mem_reg    <= byp_mem_next;
      bypass_alu_wb_reg <= byp_alu_wb_next;
      bypass_lw_wb_reg  <= byp_lw_wb_next;
    end
  end

  assign IDEXIR             = idex_ir_reg;
  assign IDEXA              = idex_a_reg;
  assign IDEXB              = idex_b_reg;
  assign bypassAfromMEM     = bypass_mem_reg[0];
  assign bypassAfromALUinWB = bypass_alu_wb_reg[0];
  assign bypassAfromLWinWB  = bypass_lw_wb_reg[0];
  assign bypassBfromMEM     = bypass_mem_reg[1];
  assign bypassBfromALUinWB = bypass_alu_wb_reg[1];
  assign bypassBfromLWinWB  = bypass_lw_wb_reg[1];

  // Instruction fields that this stage does not need, such as the immediate
  // and funct fields, or rs of the downstream instructions.
  logic unused_ir_bits;
  assign unused_ir_bits = ^{IFIDIR[15:0], EXMEMIR[25:21], EXMEMIR[10:0],
                            MEMWBIR[25:21], MEMWBIR[10:0]};

endmodule

// File: tb/tb_id_stage.sv
// -----------------------------------------------------------------------------
// tb_id_stage -- directed scoreboard bench for id_stage.
// The stimulus drives inputs on the falling edge and pushes the hand-computed
// response for that cycle. A monitor samples stall before the rising edge and
// the registered outputs after it, then pops and compares.
// -----------------------------------------------------------------------------
module tb_id_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] IFIDIR, MEMWBIR, MEMWBValue, EXMEMIR;
  logic        stall;
  logic [31:0] IDEXIR, IDEXA, IDEXB;
  logic        bypassAfromMEM, bypassAfromALUinWB, bypassAfromLWinWB;
  logic        bypassBfromMEM, bypassBfromALUinWB, bypassBfromLWinWB;

  id_stage dut (
    .clk                (clk),
    .reset              (reset),
    .IFIDIR             (IFIDIR),
    .MEMWBIR            (MEMWBIR),
    .MEMWBValue         (MEMWBValue),
    .EXMEMIR            (EXMEMIR),
    .stall              (stall),
    .IDEXIR             (IDEXIR),
    .IDEXA              (IDEXA),
    .IDEXB              (IDEXB),
    .bypassAfromMEM     (bypassAfromMEM),
    .bypassAfromALUinWB (bypassAfromALUinWB),
    .bypassAfromLWinWB  (bypassAfromLWinWB),
    .bypassBfromMEM     (bypassBfromMEM),
    .bypassBfromALUinWB (bypassBfromALUinWB),
    .bypassBfromLWinWB  (bypassBfromLWinWB)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        stall;
    logic [31:0] ir;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  byp;   // {AMEM, AALUWB, ALWWB, BMEM, BALUWB, BLWWB}
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   passes = 0;

  // Instruction encoders
  function automatic logic [31:0] rtype(input logic [5:0] op, input int rd,
                                        input int rs, input int rt,
                                        input logic [5:0] fn);
    logic [4:0] d, s, t;
    d = rd[4:0]; s = rs[4:0]; t = rt[4:0];
    return {op, s, t, d, 5'd0, fn};
  endfunction
  function automatic logic [31:0] add_i(input int rd, input int rs, input int rt);
    return rtype(6'h00, rd, rs, rt, 6'h20);
  endfunction
  function automatic logic [31:0] xor_i(input int rd, input int rs, input int rt);
    return rtype(6'h00, rd, rs, rt, 6'h26);
  endfunction
  function automatic logic [31:0] nand_i(input int rd, input int rs, input int rt);
    return rtype(6'h00, rd, rs, rt, 6'h27);
  endfunction
  function automatic logic [31:0] sgt_i(input int rd, input int rs, input int rt);
    return rtype(6'h00, rd, rs, rt, 6'h2a);
  endfunction
  function automatic logic [31:0] cindc_i(input int rd, input int rs, input int rt);
    return rtype(6'h2f, rd, rs, rt, 6'h20);
  endfunction
  function automatic logic [31:0] itype(input logic [5:0] op, input int rt,
                                        input int rs, input int imm);
    logic [4:0]  s, t;
    logic [15:0] im;
    s = rs[4:0]; t = rt[4:0]; im = imm[15:0];
    return {op, s, t, im};
  endfunction
  function automatic logic [31:0] lw_i(input int rt, input int rs, input int imm);
    return itype(6'h23, rt, rs, imm);
  endfunction
  function automatic logic [31:0] sw_i(input int rt, input int rs, input int imm);
    return itype(6'h2b, rt, rs, imm);
  endfunction

  task automatic chk(input string nm, input string what,
                     input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req)
      $display("FAIL %s.%s: got %h, required %h", nm, what, act, req);
    else
      passes++;
  endtask

  // Drive one cycle and queue its expected response.
  task automatic step(input string nm, input logic rst,
                      input logic [31:0] ifid, input logic [31:0] exmem,
                      input logic [31:0] memwb, input logic [31:0] wbval,
                      input logic e_stall, input logic [31:0] e_ir,
                      input logic [31:0] e_a, input logic [31:0] e_b,
                      input logic [5:0] e_byp);
    exp_t e;
    @(negedge clk);
    reset      = rst;
    IFIDIR     = ifid;
    EXMEMIR    = exmem;
    MEMWBIR    = memwb;
    MEMWBValue = wbval;
    e.name = nm; e.stall = e_stall; e.ir = e_ir; e.a = e_a; e.b = e_b; e.byp = e_byp;
    sb_q.push_back(e);
  endtask

  // Monitor / scoreboard
  initial begin
    logic stall_s;
    exp_t e;
    forever begin
      @(negedge clk);
      #2 stall_s = stall;
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk(e.name, "stall", {31'd0, stall_s}, {31'd0, e.stall});
        chk(e.name, "IDEXIR", IDEXIR, e.ir);
        chk(e.name, "IDEXA", IDEXA, e.a);
        chk(e.name, "IDEXB", IDEXB, e.b);
        chk(e.name, "bypass",
            {26'd0, bypassAfromMEM, bypassAfromALUinWB, bypassAfromLWinWB,
             bypassBfromMEM, bypassBfromALUinWB, bypassBfromLWinWB},
            {26'd0, e.byp});
        $display("txn %-12s stall=%b IDEXIR=%h A=%h B=%h byp=%b%b%b%b%b%b",
                 e.name, stall_s, IDEXIR, IDEXA, IDEXB,
                 bypassAfromMEM, bypassAfromALUinWB, bypassAfromLWinWB,
                 bypassBfromMEM, bypassBfromALUinWB, bypassBfromLWinWB);
      end
    end
  end

  initial begin
    reset = 1'b1; IFIDIR = '0; EXMEMIR = '0; MEMWBIR = '0; MEMWBValue = '0;
    // First reset edge brings state out of X; it is not scored.
    @(negedge clk);
    //    name          rst   IFIDIR              EXMEMIR          MEMWBIR          value          stall IDEXIR             A             B             byp
    step("reset",       1'b1, 32'h0,              32'h0,           add_i(5,0,0),    32'hDEAD,      1'b0, 32'h0,             32'h0,        32'h0,        6'b000000);
    step("wthru",       1'b0, add_i(6,5,0),       32'h0,           add_i(5,0,0),    32'h1234,      1'b0, add_i(6,5,0),      32'h1234,     32'h0,        6'b000000);
    step("ld_add3",     1'b0, add_i(3,1,2),       32'h0,           add_i(1,0,0),    32'h11,        1'b0, add_i(3,1,2),      32'h11,       32'h0,        6'b000000);
    step("alu_fwd",     1'b0, xor_i(4,3,3),       32'h0,           32'h0,           32'h0,         1'b0, xor_i(4,3,3),      32'h0,        32'h0,        6'b100100);
    step("ld_nand7",    1'b0, nand_i(7,1,5),      32'h0,           32'h0,           32'h0,         1'b0, nand_i(7,1,5),     32'h11,       32'h1234,     6'b000000);
    step("mem_prio",    1'b0, sgt_i(8,7,0),       add_i(7,0,0),    32'h0,           32'h0,         1'b0, sgt_i(8,7,0),      32'h0,        32'h0,        6'b100000);
    step("ld_bubble",   1'b0, 32'h0000_0020,      32'h0,           32'h0,           32'h0,         1'b0, 32'h0000_0020,     32'h0,        32'h0,        6'b000000);
    step("wb_alu",      1'b0, sgt_i(8,7,0),       add_i(7,0,0),    32'h0,           32'h0,         1'b0, sgt_i(8,7,0),      32'h0,        32'h0,        6'b010000);
    step("ld_lw9",      1'b0, lw_i(9,1,4),        32'h0,           32'h0,           32'h0,         1'b0, lw_i(9,1,4),       32'h11,       32'h0,        6'b000000);
    step("lu_stall",    1'b0, add_i(10,9,2),      32'h0,           32'h0,           32'h0,         1'b1, 32'h0000_0020,     32'h0,        32'h0,        6'b000000);
    step("lu_resume",   1'b0, add_i(10,9,2),      lw_i(9,1,4),     32'h0,           32'h0,         1'b0, add_i(10,9,2),     32'h0,        32'h0,        6'b001000);
    step("ld_add_r0",   1'b0, add_i(0,1,2),       32'h0,           32'h0,           32'h0,         1'b0, add_i(0,1,2),      32'h11,       32'h0,        6'b000000);
    step("r0_nobyp",    1'b0, add_i(3,0,0),       add_i(0,0,0),    add_i(0,0,0),    32'hFFFF_FFFF, 1'b0, add_i(3,0,0),      32'h0,        32'h0,        6'b000000);
    step("r0_read",     1'b0, add_i(3,0,0),       32'h0,           32'h0,           32'h0,         1'b0, add_i(3,0,0),      32'h0,        32'h0,        6'b000000);
    step("ld_lw_r0",    1'b0, lw_i(0,1,0),        32'h0,           32'h0,           32'h0,         1'b0, lw_i(0,1,0),       32'h11,       32'h0,        6'b000000);
    step("sw_b_wb",     1'b0, sw_i(5,1,8),        cindc_i(5,0,0),  32'h0,           32'h0,         1'b0, sw_i(5,1,8),       32'h11,       32'h1234,     6'b000010);
    step("lw_rt_unuse", 1'b0, lw_i(12,3,0),       add_i(12,0,0),   32'h0,           32'h0,         1'b0, lw_i(12,3,0),      32'h0,        32'h0,        6'b000000);
    step("lu_rt_stall", 1'b0, add_i(13,1,12),     32'h0,           32'h0,           32'h0,         1'b1, 32'h0000_0020,     32'h0,        32'h0,        6'b000000);
    step("preload55",   1'b0, lw_i(21,20,0),      32'h0,           add_i(20,0,0),   32'h55,        1'b0, lw_i(21,20,0),     32'h55,       32'h0,        6'b000000);
    step("rst_stall",   1'b1, add_i(22,21,20),    32'h0,           add_i(20,0,0),   32'h77,        1'b1, 32'h0,             32'h0,        32'h0,        6'b000000);
    step("post_rst",    1'b0, add_i(22,20,20),    32'h0,           32'h0,           32'h0,         1'b0, add_i(22,20,20),   32'h0,        32'h0,        6'b000000);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && sb_q.size() > 0; i++)
      @(negedge clk);
    checks++;
    if (sb_q.size() != 0)
      $display("FAIL drain: %0d responses still pending, required 0", sb_q.size());
    else
      passes++;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
